ddr_lane_dly_ctrl: RTL and testbench

//  Multi-lane sequencer for IOD delay-line controls (DELAY_LINE_LOAD/MOVE/DIRECTION, OUT_OF_RANGE) of NUM_LANES DDR4 DQ/DM lanes.
//  - Accepts one tap command at a time from the training logic.
//  - Spaces MOVE pulses by a settle interval and tracks the tap position of every lane.
//  - Stops on boundary or hardware out-of-range and returns a status response.
//  - Sits between the training FSM and the per-lane PF_IOD wrappers, in the FAB_CLK domain.

---
 rtl/ddr_dly_pkg.sv | 17 +
 rtl/ddr_dly_tap_bank.sv | 25 ++
 rtl/ddr_lane_dly_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ddr_lane_dly_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_dly_pkg.sv
// ddr_dly_pkg: command encodings and sequencer states shared by the delay-line controller
package ddr_dly_pkg;
   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_SET  = 2'b11
   } op_e;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD,
      ST_DIR,
      ST_MV,
      ST_SETTLE,
      ST_DONE
   } state_e;
endpackage

// File: rtl/ddr_dly_tap_bank.sv
// ddr_dly_tap_bank: per-lane tap position registers driven by clear/inc/dec strobes
module ddr_dly_tap_bank #(
   parameter int NUM_LANES = 2,
   parameter int TAP_W     = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_LANES-1:0]             clr,
   input  logic [NUM_LANES-1:0]             inc,
   input  logic [NUM_LANES-1:0]             dec,
   output logic [NUM_LANES-1:0][TAP_W-1:0]  tap,
   output logic [NUM_LANES*TAP_W-1:0]       tap_pos
);
   logic [NUM_LANES-1:0][TAP_W-1:0] tap_q, tap_d;
   always_comb begin
      tap_d = tap_q;
      for (int l = 0; l < NUM_LANES; l++)
         tap_d[l] = clr[l] ? '0 : inc[l] ? tap_q[l] + 1'b1 : dec[l] ? tap_q[l] - 1'b1 : tap_q[l];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) tap_q <= '0;
      else        tap_q <= tap_d;
   assign tap     = tap_q;
   assign tap_pos = tap_q;
endmodule

// File: rtl/ddr_lane_dly_ctrl.sv
// ddr_lane_dly_ctrl: sequences IOD delay-line LOAD/MOVE pulses across DQ lanes,
// spacing moves by a settle interval and reporting the resulting tap position
module ddr_lane_dly_ctrl
   import ddr_dly_pkg::*;
#(
   parameter  int NUM_LANES  = 2,
   parameter  int TAP_W      = 8,
   parameter  int TAP_MAX    = 127,
   parameter  int SETTLE_CYC = 4,
   localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                       FAB_CLK,
   input  logic                       ARST_N,
   input  logic                       REQ_VALID,
   output logic                       REQ_READY,
   input  logic [LANE_W-1:0]          REQ_LANE,
   input  logic [1:0]                 REQ_OP,
   input  logic [TAP_W-1:0]           REQ_STEPS,
   output logic                       RSP_VALID,
   input  logic                       RSP_READY,
   output logic [TAP_W-1:0]           RSP_TAP,
   output logic                       RSP_OOR,
   output logic                       RSP_ERR,
   output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
   output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
   input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
   output logic [NUM_LANES*TAP_W-1:0] TAP_POS
);
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [TAP_W-1:0] TMAX = TAP_W'(TAP_MAX);
   state_e                          state_q, state_d;
   op_e                             op_q, op_d;
   logic [LANE_W-1:0]               lane_q, lane_d;
   logic [TAP_W-1:0]                rem_q, rem_d, rsp_tap_q, rsp_tap_d, tap_cur;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            oor_q, oor_d, err_q, err_d, nxt_dir_q, nxt_dir_d;
   logic                            ready_q, ready_d, rsp_valid_q, rsp_valid_d;
   logic                            rsp_oor_q, rsp_oor_d, rsp_err_q, rsp_err_d;
   logic                            can_step, step_go, step_oor;
   logic [NUM_LANES-1:0]            load_q, load_d, move_q, move_d, dir_q, dir_d;
   logic [NUM_LANES-1:0]            clr, inc, dec;
   logic [NUM_LANES-1:0][TAP_W-1:0] tap;
   ddr_dly_tap_bank #(.NUM_LANES(NUM_LANES), .TAP_W(TAP_W)) u_bank (
      .clk(FAB_CLK), .rst_n(ARST_N), .clr(clr), .inc(inc), .dec(dec), .tap(tap), .tap_pos(TAP_POS)
   );
   always_comb begin
      tap_cur   = tap[lane_q];
      can_step  = (op_q == OP_DEC) ? (tap_cur != '0) : (tap_cur < TMAX);
      step_go   = (rem_q != '0) && can_step;
      step_oor  = (rem_q != '0) && !can_step;
      state_d   = state_q;
      op_d      = op_q;
      lane_d    = lane_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      oor_d     = oor_q;
      err_d     = err_q;
      nxt_dir_d = nxt_dir_q;
      clr       = '0;
      inc       = '0;
      dec       = '0;
      case (state_q)
         ST_IDLE: if (REQ_VALID && ready_q) begin
            lane_d    = REQ_LANE;
            op_d      = op_e'(REQ_OP);
            err_d     = int'(REQ_LANE) >= NUM_LANES;
            oor_d     = (op_d == OP_SET) && (REQ_STEPS > TMAX);
            rem_d     = (op_d == OP_LOAD) ? '0 : oor_d ? TMAX : REQ_STEPS;
            nxt_dir_d = op_d == OP_SET;
            state_d   = err_d ? ST_DONE : (op_d inside {OP_LOAD, OP_SET}) ? ST_LD : ST_DIR;
         end
         ST_LD: begin
            clr[lane_q] = 1'b1;
            cnt_d       = CNT_W'(SETTLE_CYC - 1);
            state_d     = ST_SETTLE;
         end
         ST_DIR: begin
            oor_d   = oor_q | step_oor;
            state_d = step_go ? ST_MV : ST_DONE;
         end
         ST_MV: begin
            inc[lane_q] = op_q != OP_DEC;
            dec[lane_q] = op_q == OP_DEC;
            rem_d       = rem_q - 1'b1;
            cnt_d       = CNT_W'(SETTLE_CYC - 1);
            state_d     = ST_SETTLE;
         end
         ST_SETTLE:
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
               oor_d   = 1'b1;
               state_d = ST_DONE;
            end else if (nxt_dir_q) begin
               nxt_dir_d = 1'b0;
               state_d   = ST_DIR;
            end else begin
               oor_d   = oor_q | step_oor;
               state_d = step_go ? ST_MV : ST_DONE;
            end
         ST_DONE: if (RSP_READY) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // outputs are registered from the next state so pulses line up with the state they belong to
      ready_d     = state_d == ST_IDLE;
      rsp_valid_d = state_d == ST_DONE;
      rsp_tap_d   = (rsp_valid_d && !err_d) ? tap_cur : '0;
      rsp_oor_d   = rsp_valid_d && oor_d;
      rsp_err_d   = rsp_valid_d && err_d;
      load_d      = '0;
      move_d      = '0;
      dir_d       = dir_q;
      if (state_d == ST_LD)  load_d[lane_d] = 1'b1;
      if (state_d == ST_MV)  move_d[lane_d] = 1'b1;
      if (state_d == ST_DIR) dir_d[lane_d]  = op_d != OP_DEC;
   end
   always_ff @(posedge FAB_CLK or negedge ARST_N)
      if (!ARST_N) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LOAD;
         lane_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         oor_q       <= 1'b0;
         err_q       <= 1'b0;
         nxt_dir_q   <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tap_q   <= '0;
         rsp_oor_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         load_q      <= '0;
         move_q      <= '0;
         dir_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lane_q      <= lane_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         oor_q       <= oor_d;
         err_q       <= err_d;
         nxt_dir_q   <= nxt_dir_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tap_q   <= rsp_tap_d;
         rsp_oor_q   <= rsp_oor_d;
         rsp_err_q   <= rsp_err_d;
         load_q      <= load_d;
         move_q      <= move_d;
         dir_q       <= dir_d;
      end
   assign REQ_READY            = ready_q;
   assign RSP_VALID            = rsp_valid_q;
   assign RSP_TAP              = rsp_tap_q;
   assign RSP_OOR              = rsp_oor_q;
   assign RSP_ERR              = rsp_err_q;
   assign DELAY_LINE_LOAD      = load_q;
   assign DELAY_LINE_MOVE      = move_q;
   assign DELAY_LINE_DIRECTION = dir_q;
endmodule

// File: tb/tb_ddr_lane_dly_ctrl.sv
// tb_ddr_lane_dly_ctrl: directed and random tap commands checked against a cycle-count model
module tb_ddr_lane_dly_ctrl;
   localparam int TMAX = 127, S = 4, S1 = S + 1;
   localparam int OP_LOAD = 0, OP_INC = 1, OP_DEC = 2, OP_SET = 3;
   localparam int NEVER = 1 << 30;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic       req_valid = 0, req_ready, req_lane = 0, rsp_valid, rsp_ready = 1, rsp_oor, rsp_err;
   logic [1:0] req_op = 0, load, move, dirs, oor_in = 0;
   logic [7:0] req_steps = 0, rsp_tap;
   logic [15:0] tap_pos;
   logic       e_valid = 0, e_ready, e_rsp_valid, e_rsp_oor, e_rsp_err;
   logic [1:0] e_lane = 0, e_op = 0;
   logic [7:0] e_steps = 0, e_rsp_tap;
   logic [2:0] e_load, e_move, e_dir;
   logic [23:0] e_tap_pos;
   int errors = 0, checks = 0;
   int tap_m[2];
   bit dir_m[2];
   ddr_lane_dly_ctrl #(.NUM_LANES(2), .TAP_W(8), .TAP_MAX(TMAX), .SETTLE_CYC(S)) dut (
      .FAB_CLK(clk), .ARST_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_LANE(req_lane), .REQ_OP(req_op), .REQ_STEPS(req_steps), .RSP_VALID(rsp_valid),
      .RSP_READY(rsp_ready), .RSP_TAP(rsp_tap), .RSP_OOR(rsp_oor), .RSP_ERR(rsp_err),
      .DELAY_LINE_LOAD(load), .DELAY_LINE_MOVE(move), .DELAY_LINE_DIRECTION(dirs),
      .DELAY_LINE_OUT_OF_RANGE(oor_in), .TAP_POS(tap_pos)
   );
   // a three-lane instance so an out-of-range lane index is expressible
   ddr_lane_dly_ctrl #(.NUM_LANES(3), .TAP_W(8), .TAP_MAX(TMAX), .SETTLE_CYC(S)) dut3 (
      .FAB_CLK(clk), .ARST_N(rst_n), .REQ_VALID(e_valid), .REQ_READY(e_ready),
      .REQ_LANE(e_lane), .REQ_OP(e_op), .REQ_STEPS(e_steps), .RSP_VALID(e_rsp_valid),
      .RSP_READY(1'b1), .RSP_TAP(e_rsp_tap), .RSP_OOR(e_rsp_oor), .RSP_ERR(e_rsp_err),
      .DELAY_LINE_LOAD(e_load), .DELAY_LINE_MOVE(e_move), .DELAY_LINE_DIRECTION(e_dir),
      .DELAY_LINE_OUT_OF_RANGE(3'b000), .TAP_POS(e_tap_pos)
   );
   task automatic wait_ready();
      int w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_timeout: REQ_READY=%b required 1", req_ready);
      end
   endtask
   task automatic run_cmd(input int lane, input int op, input int steps, input int oor_from, input int hold);
      int off = 0, n = 0, start = 0, tgt = 0, room, rsp_cyc, got = -1, c = 0;
      bit eoor = 0, dirv = 1;
      logic [1:0] el, em, ed;
      logic [7:0] htap;
      logic hoor;
      if (op != OP_LOAD) begin
         if (op == OP_SET) begin
            off  = S1;
            tgt  = steps > TMAX ? TMAX : steps;
            eoor = steps > TMAX;
         end else begin
            start = tap_m[lane];
            tgt   = steps;
            dirv  = op == OP_INC;
         end
         room = dirv ? TMAX - start : start;
         n    = tgt < room ? tgt : room;
         if (tgt > room) eoor = 1;
         for (int k = 0; k < n; k++)
            if (oor_from <= off + 2 + k * S1 + S) begin
               n    = k + 1;
               eoor = 1;
               break;
            end
      end
      rsp_cyc   = (op == OP_LOAD) ? 2 + S : off + 2 + n * S1;
      rsp_ready = hold == 0;
      wait_ready();
      req_valid = 1;
      req_lane  = 1'(lane);
      req_op    = 2'(op);
      req_steps = 8'(steps);
      while (got < 0 && c < rsp_cyc + 20) begin
         @(negedge clk);
         c++;
         if (c == 1) req_valid = 0;
         el = ((op == OP_LOAD || op == OP_SET) && c == 1) ? 2'(1 << lane) : 2'b00;
         em = (c >= off + 2 && (c - off - 2) % S1 == 0 && (c - off - 2) / S1 < n) ? 2'(1 << lane) : 2'b00;
         ed = {dir_m[1], dir_m[0]};
         if (op != OP_LOAD && c >= off + 1) ed[lane] = dirv;
         checks++;
         if ({load, move, dirs} !== {el, em, ed}) begin
            errors++;
            $display("FAIL pulses op%0d cycle %0d: load/move/dir=%b/%b/%b required %b/%b/%b",
                     op, c, load, move, dirs, el, em, ed);
         end
         if (rsp_valid) got = c;
         oor_in[lane] = c >= oor_from;
      end
      if (op != OP_LOAD) dir_m[lane] = dirv;
      tap_m[lane] = (op == OP_LOAD) ? 0 : (op == OP_SET) ? n : dirv ? start + n : start - n;
      checks++;
      if (got !== rsp_cyc) begin
         errors++;
         $display("FAIL rsp_cycle op%0d: got %0d required %0d", op, got, rsp_cyc);
      end
      checks++;
      if ({rsp_tap, rsp_oor, rsp_err} !== {8'(tap_m[lane]), eoor, 1'b0}) begin
         errors++;
         $display("FAIL rsp_fields op%0d: tap=%0d oor=%b err=%b required tap=%0d oor=%b err=0",
                  op, rsp_tap, rsp_oor, rsp_err, tap_m[lane], eoor);
      end
      checks++;
      if (tap_pos !== {8'(tap_m[1]), 8'(tap_m[0])}) begin
         errors++;
         $display("FAIL tap_pos: got %h required %h", tap_pos, {8'(tap_m[1]), 8'(tap_m[0])});
      end
      htap = rsp_tap;
      hoor = rsp_oor;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, req_ready, rsp_tap, rsp_oor} !== {1'b1, 1'b0, htap, hoor}) begin
            errors++;
            $display("FAIL rsp_hold %0d: valid/ready/tap/oor=%b/%b/%0d/%b required 1/0/%0d/%b",
                     h, rsp_valid, req_ready, rsp_tap, rsp_oor, htap, hoor);
         end
      end
      rsp_ready = 1;
      oor_in    = 0;
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL ready_after_rsp: ready/valid=%b%b required 10", req_ready, rsp_valid);
      end
   endtask
   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_tap, rsp_oor, rsp_err, load, move, dirs, tap_pos} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b valid=%b load=%b move=%b dir=%b taps=%h required all 0",
                  req_ready, rsp_valid, load, move, dirs, tap_pos);
      end
      rst_n = 1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_at_release: got %b required 0", req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || e_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release: got %b/%b required 1/1", req_ready, e_ready);
      end
   endtask
   task automatic test_bad_lane();
      int got = -1;
      e_valid = 1;
      e_lane  = 2'd3;
      e_op    = 2'(OP_INC);
      e_steps = 8'd4;
      for (int c = 1; c <= 10 && got < 0; c++) begin
         @(negedge clk);
         if (c == 1) e_valid = 0;
         checks++;
         if ({e_load, e_move} !== 6'b0) begin
            errors++;
            $display("FAIL bad_lane_pulses cycle %0d: load/move=%b/%b required 0", c, e_load, e_move);
         end
         if (e_rsp_valid) got = c;
      end
      checks++;
      if (got !== 1) begin
         errors++;
         $display("FAIL bad_lane_rsp_cycle: got %0d required 1", got);
      end
      checks++;
      if ({e_rsp_err, e_rsp_oor, e_rsp_tap, e_tap_pos} !== {1'b1, 1'b0, 8'd0, 24'd0}) begin
         errors++;
         $display("FAIL bad_lane_rsp: err=%b oor=%b tap=%0d taps=%h required 1/0/0/0",
                  e_rsp_err, e_rsp_oor, e_rsp_tap, e_tap_pos);
      end
   endtask
   task automatic test_random();
      int lane, op, steps, of;
      for (int i = 0; i < 14; i++) begin
         lane  = $urandom_range(0, 1);
         op    = $urandom_range(0, 3);
         steps = (op == OP_SET) ? $urandom_range(0, 140) : $urandom_range(0, 8);
         of    = ((op == OP_INC || op == OP_DEC) && $urandom_range(0, 3) == 0) ? $urandom_range(3, 40) : NEVER;
         run_cmd(lane, op, steps, of, $urandom_range(0, 3) == 0 ? 2 : 0);
      end
   endtask
   task automatic test_reset_abort();
      wait_ready();
      req_valid = 1;
      req_lane  = 1'b0;
      req_op    = 2'(tap_m[0] < 100 ? OP_INC : OP_DEC);
      req_steps = 8'd5;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 0;
      end
      rst_n = 0;
      #1;
      checks++;
      if ({load, move, dirs, tap_pos, rsp_valid, req_ready} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: load=%b move=%b dir=%b taps=%h valid=%b ready=%b required 0",
                  load, move, dirs, tap_pos, rsp_valid, req_ready);
      end
      tap_m = '{0, 0};
      dir_m = '{0, 0};
      repeat (3) @(negedge clk);
      rst_n = 1;
      #1;
      checks++;
      if ({rsp_valid, req_ready} !== 2'b00) begin
         errors++;
         $display("FAIL abort_release: valid/ready=%b%b required 00", rsp_valid, req_ready);
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL abort_ready: valid/ready=%b%b required 01", rsp_valid, req_ready);
      end
      run_cmd(0, OP_INC, 2, NEVER, 0);
   endtask
   initial begin
      tap_m = '{0, 0};
      dir_m = '{0, 0};
      test_reset();
      run_cmd(1, OP_LOAD, 0, NEVER, 0);
      run_cmd(0, OP_INC, 3, NEVER, 0);
      run_cmd(0, OP_LOAD, 0, NEVER, 0);
      run_cmd(0, OP_DEC, 1, NEVER, 0);
      test_bad_lane();
      run_cmd(0, OP_INC, 5, 8, 0);
      run_cmd(1, OP_SET, 130, NEVER, 10);
      run_cmd(1, OP_INC, 2, NEVER, 0);
      test_random();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
